main_memory_arbiter: RTL

- Shares the single main-memory port between the instruction-cache miss path and the data-cache miss/write-back path.
- Sits between both caches and the main-memory model. Each cache sees its own private memory interface with busywait.
- Arbitrates simultaneous misses with alternating priority, so neither the fetch stage nor the memory-access stage starves.
- Its busywait outputs feed the caches, whose busywaits in turn stall the pipeline registers.

---
 rtl/main_memory_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/main_memory_arbiter.sv
// Main-memory arbiter: shares one block-wide memory port between the
// I-cache miss path and the D-cache miss/write-back path.
module main_memory_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_mem_read,
    input  logic [ADDR_WIDTH-1:0] i_mem_address,
    output logic [DATA_WIDTH-1:0] i_mem_readdata,
    output logic                  i_mem_busywait,
    input  logic                  d_mem_read,
    input  logic                  d_mem_write,
    input  logic [ADDR_WIDTH-1:0] d_mem_address,
    input  logic [DATA_WIDTH-1:0] d_mem_writedata,
    output logic [DATA_WIDTH-1:0] d_mem_readdata,
    output logic                  d_mem_busywait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    input  logic                  mem_busywait,
    output logic [1:0]            owner
);

    typedef enum logic [2:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DONE_I,
        DONE_D
    } state_t;

    typedef enum logic {
        SRC_I,
        SRC_D
    } src_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    state_t state;
    src_t   last_served;
    logic   started;

    logic i_req;
    logic d_req;
    logic grant_d;
    logic grant_i;
    logic mem_done;

    assign i_req = i_mem_read;
    assign d_req = d_mem_read | d_mem_write;

    // Alternating priority on a tie: D wins unless it was served last
    assign grant_d = d_req & (~i_req | (last_served == SRC_I));
    assign grant_i = i_req & ~grant_d;

    // First SERVE cycle never counts as completion
    assign mem_done = started & ~mem_busywait;

    // Stalls follow the request directly and open only in DONE
    assign i_mem_busywait = reset & i_req & (state != DONE_I);
    assign d_mem_busywait = reset & d_req & (state != DONE_D);

    // Arbitration FSM with registered memory commands and read-data latches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            last_served    <= SRC_I;
            started        <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_writedata  <= '0;
            i_mem_readdata <= '0;
            d_mem_readdata <= '0;
            owner          <= OWN_NONE;
        end else begin
            unique case (state)
                IDLE: begin
                    started <= 1'b0;
                    if (grant_d) begin
                        state         <= SERVE_D;
                        owner         <= OWN_D;
                        mem_read      <= ~d_mem_write;
                        mem_write     <= d_mem_write;
                        mem_address   <= d_mem_address;
                        mem_writedata <= d_mem_writedata;
                    end else if (grant_i) begin
                        state         <= SERVE_I;
                        owner         <= OWN_I;
                        mem_read      <= 1'b1;
                        mem_write     <= 1'b0;
                        mem_address   <= i_mem_address;
                        mem_writedata <= '0;
                    end
                end
                SERVE_I: begin
                    started <= 1'b1;
                    if (mem_done) begin
                        if (i_req) begin
                            i_mem_readdata <= mem_readdata;
                        end
                        last_served <= SRC_I;
                        state       <= DONE_I;
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        owner       <= OWN_NONE;
                    end
                end
                SERVE_D: begin
                    started <= 1'b1;
                    if (mem_done) begin
                        if (mem_read && d_req) begin
                            d_mem_readdata <= mem_readdata;
                        end
                        last_served <= SRC_D;
                        state       <= DONE_D;
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        owner       <= OWN_NONE;
                    end
                end
                DONE_I, DONE_D: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    owner     <= OWN_NONE;
                end
            endcase
        end
    end

endmodule
